// File: rtl/squareroot_mahsqr_k14_if.sv
// Radicand/result bus for the approximate square-root block.
//   R         : 16-bit unsigned radicand (driven by master)
//   in_valid  : R is valid this cycle (driven by master)
//   final_op  : registered 8-bit approximate root (driven by slave)
//   out_valid : final_op holds the result of a valid input (driven by slave)
interface squareroot_mahsqr_k14_if;
  logic [15:0] R;
  logic        in_valid;
  logic [7:0]  final_op;
  logic        out_valid;

  modport master (
    output R,
    output in_valid,
    input  final_op,
    input  out_valid
  );

  modport slave (
    input  R,
    input  in_valid,
    output final_op,
    output out_valid
  );
endinterface

// File: rtl/squareroot_mahsqr_k14.sv
// Approximate integer square root: restoring digit-by-digit array, 8 rows,
// with the two least-significant columns of rows 0..6 (14 cells) built from
// approximate subtractor cells. One output register stage.
//   clk : rising-edge clock
//   rst : synchronous active-high reset (priority over in_valid)
//   bus : slave side of squareroot_mahsqr_k14_if (R/in_valid in,
//         final_op/out_valid out, both outputs registered)
module squareroot_mahsqr_k14 (
  input  logic                           clk,
  input  logic                           rst,
  squareroot_mahsqr_k14_if.slave         bus
);

  logic [7:0] root_s;

  // Exact full-subtractor borrow-out.
  function automatic logic bout_exact(input logic a, input logic b, input logic bin);
    return (~a & b) | (~(a ^ b) & bin);
  endfunction

  // Approximate borrow-out: over-borrows only for a=1, b=0, bin=1.
  function automatic logic bout_approx(input logic a, input logic b, input logic bin);
    return (~a & b) | bin;
  endfunction

  // Full array evaluation. The borrow chain is 16 bits wide so the
  // subtraction is never truncated; the upper cells see constant zeros on the
  // trial side and collapse to simple borrow propagation.
  function automatic logic [7:0] asqrt(input logic [15:0] rad);
    logic [7:0]  q_v;
    logic [15:0] rem_v;
    logic [15:0] rp_v;
    logic [15:0] trial_v;
    logic [15:0] diff_v;
    logic        borrow_v;
    q_v   = 8'd0;
    rem_v = 16'd0;
    for (int i = 7; i >= 0; i--) begin
      rp_v     = {rem_v[13:0], rad[2*i +: 2]};
      trial_v  = {6'd0, q_v, 2'b01};
      diff_v   = 16'd0;
      borrow_v = 1'b0;
      for (int j = 0; j < 16; j++) begin
        diff_v[j] = rp_v[j] ^ trial_v[j] ^ borrow_v;
        // Columns 0 and 1 of rows 0..6 are the approximate cells.
        if ((i <= 6) && (j <= 1)) begin
          borrow_v = bout_approx(rp_v[j], trial_v[j], borrow_v);
        end else begin
          borrow_v = bout_exact(rp_v[j], trial_v[j], borrow_v);
        end
      end
      // No final borrow: accept the digit; otherwise restore the remainder.
      if (!borrow_v) begin
        q_v   = {q_v[6:0], 1'b1};
        rem_v = diff_v;
      end else begin
        q_v   = {q_v[6:0], 1'b0};
        rem_v = rp_v;
      end
    end
    return q_v;
  endfunction

  // Combinational array on the live radicand (evaluated regardless of in_valid).
  always_comb begin
    root_s = asqrt(bus.R);
  end

  // Output register stage with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      bus.final_op  <= 8'd0;
      bus.out_valid <= 1'b0;
    end else begin
      bus.final_op  <= root_s;
      bus.out_valid <= bus.in_valid;
    end
  end

endmodule

// File: tb/tb_squareroot_mahsqr_k14.sv
// Self-checking bench for squareroot_mahsqr_k14: directed cases, streaming,
// mid-stream reset, random traffic and an exhaustive sweep with error metrics.
module tb_squareroot_mahsqr_k14;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  squareroot_mahsqr_k14_if bus ();

  squareroot_mahsqr_k14 dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Reference: greedy root-digit selection in plain integers. In rows 0..6 a
  // partial remainder ending in binary 10 only accepts the digit when it
  // clears trial+4, and the accepted remainder is then 4 lower.
  function automatic int model_asqrt(input int rad);
    int q = 0;
    int r = 0;
    int rp, t;
    for (int i = 7; i >= 0; i--) begin
      rp = r * 4 + ((rad >> (2 * i)) % 4);
      t  = q * 4 + 1;
      if (i <= 6 && (rp % 4) == 2) begin
        if (rp >= t + 4) begin q = 2 * q + 1; r = rp - t - 4; end
        else             begin q = 2 * q;     r = rp;         end
      end else begin
        if (rp >= t) begin q = 2 * q + 1; r = rp - t; end
        else         begin q = 2 * q;     r = rp;     end
      end
    end
    return q;
  endfunction

  function automatic int exact_isqrt(input int rad);
    int s = 0;
    while ((s + 1) * (s + 1) <= rad) s++;
    return s;
  endfunction

  task automatic drive(input int r, input logic v);
    @(negedge clk);
    bus.R        = r[15:0];
    bus.in_valid = v;
  endtask

  task automatic sample();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(16'hFFFF, 1'b1);
    sample();
    n_checks++;
    if (bus.final_op !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_final_op: got %0d expected 0", bus.final_op);
    end
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_out_valid: got %b expected 0", bus.out_valid);
    end
    @(negedge clk);
    rst = 1'b0;
    sample();
    n_checks++;
    if (bus.final_op !== 8'(model_asqrt(65535)) || bus.out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: got %0d/%b expected %0d/1",
               bus.final_op, bus.out_valid, model_asqrt(65535));
    end
  endtask

  task automatic test_directed();
    int rs [7] = '{0, 1, 3, 4, 6, 2, 10};
    int ex [7] = '{0, 1, 1, 2, 2, 0, 1};
    for (int k = 0; k < 7; k++) begin
      drive(rs[k], 1'b1);
      sample();
      n_checks++;
      if (bus.final_op !== 8'(ex[k])) begin
        n_fail++;
        $display("FAIL directed R=%0d: got %0d expected %0d", rs[k], bus.final_op, ex[k]);
      end
    end
  endtask

  task automatic test_back_to_back();
    int rs [4] = '{1, 4, 10, 0};
    int ex [4] = '{1, 2, 1, 0};
    for (int k = 0; k < 4; k++) begin
      drive(rs[k], 1'b1);
      sample();
      n_checks++;
      if (bus.final_op !== 8'(ex[k]) || bus.out_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL stream[%0d]: got %0d/%b expected %0d/1", k, bus.final_op, bus.out_valid, ex[k]);
      end
    end
    drive(0, 1'b0);
    sample();
    n_checks++;
    if (bus.out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL stream_drop_valid: got %b expected 0", bus.out_valid);
    end
  endtask

  task automatic test_midstream_reset();
    int r;
    for (int k = 0; k < 6; k++) begin
      r = int'($urandom_range(0, 65535));
      if (k == 3) rst = 1'b1;
      drive(r, 1'b1);
      @(negedge clk);
      // rst is changed just before drive's next negedge assignment point
      sample();
      n_checks++;
      if (k == 3) begin
        if (bus.final_op !== 8'd0 || bus.out_valid !== 1'b0) begin
          n_fail++;
          $display("FAIL midstream_reset: got %0d/%b expected 0/0", bus.final_op, bus.out_valid);
        end
        rst = 1'b0;
      end else begin
        if (bus.final_op !== 8'(model_asqrt(r)) || bus.out_valid !== 1'b1) begin
          n_fail++;
          $display("FAIL midstream[%0d] R=%0d: got %0d/%b expected %0d/1",
                   k, r, bus.final_op, bus.out_valid, model_asqrt(r));
        end
      end
    end
  endtask

  task automatic test_random();
    int   r;
    logic v;
    for (int k = 0; k < 300; k++) begin
      r = int'($urandom_range(0, 65535));
      v = 1'($urandom_range(0, 1));
      drive(r, v);
      sample();
      n_checks++;
      if (bus.final_op !== 8'(model_asqrt(r)) || bus.out_valid !== v) begin
        n_fail++;
        $display("FAIL random R=%0d: got %0d/%b expected %0d/%b",
                 r, bus.final_op, bus.out_valid, model_asqrt(r), v);
      end
    end
  endtask

  task automatic test_exhaustive();
    int  exp_q, ex, ed;
    int  err_cnt = 0;
    int  ed_max  = 0;
    int  printed = 0;
    real sum_ed  = 0.0;
    real sum_red = 0.0;
    for (int x = 0; x < 65536; x++) begin
      drive(x, 1'b1);
      sample();
      exp_q = model_asqrt(x);
      ex    = exact_isqrt(x);
      n_checks++;
      if (bus.final_op !== 8'(exp_q)) begin
        n_fail++;
        if (printed < 10) begin
          printed++;
          $display("FAIL sweep_model R=%0d: got %0d expected %0d", x, bus.final_op, exp_q);
        end
      end
      n_checks++;
      if (int'(bus.final_op) > ex) begin
        n_fail++;
        if (printed < 10) begin
          printed++;
          $display("FAIL sweep_bound R=%0d: got %0d exceeds exact %0d", x, bus.final_op, ex);
        end
      end
      ed = ex - int'(bus.final_op);
      if (ed < 0) ed = -ed;
      if (ed != 0) err_cnt++;
      if (ed > ed_max) ed_max = ed;
      sum_ed += real'(ed);
      if (x > 0) sum_red += real'(ed) / real'(ex);
    end
    $display("Error metrics: ER=%f NMED=%e MRED=%e EDmax=%0d",
             real'(err_cnt) / 65536.0, sum_ed / (255.0 * 65536.0),
             sum_red / 65535.0, ed_max);
  endtask

  initial begin
    rst          = 1'b0;
    bus.R        = 16'd0;
    bus.in_valid = 1'b0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_midstream_reset();
    test_random();
    test_exhaustive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
